// File: rtl/vx_dcr_write_bridge_pkg.sv
// ============================================================================
// vx_dcr_write_bridge_pkg
//   Definitions shared by the DCR write bridge and its request FIFO:
//   - default DCR address/data widths
//   - base-state DCR address window [DCR_BASE_STATE_BEGIN, DCR_BASE_STATE_END)
//   - gap counter width (GAP_CYCLES is limited to 0..15)
//   - dcr_req_t: default-width request record. The bridge stores its FIFO
//     entries packed in the same order, {addr, data}.
//   - dcr_addr_in_range(): base-state window test used by the optional
//     range filter
// ============================================================================
package vx_dcr_write_bridge_pkg;

    localparam int DCR_ADDR_BITS = 12;
    localparam int DCR_DATA_BITS = 32;

    // Base-state DCR window, end exclusive.
    localparam int unsigned DCR_BASE_STATE_BEGIN = 32'h0000_0001;
    localparam int unsigned DCR_BASE_STATE_END   = 32'h0000_000A;

    localparam int GAP_CNT_BITS = 4;

    typedef struct packed {
        logic [DCR_ADDR_BITS-1:0] addr;
        logic [DCR_DATA_BITS-1:0] data;
    } dcr_req_t;

    function automatic logic dcr_addr_in_range(input logic [31:0] addr);
        return (addr >= DCR_BASE_STATE_BEGIN) && (addr < DCR_BASE_STATE_END);
    endfunction

endpackage

// File: rtl/vx_dcr_write_bridge_fifo.sv
// ============================================================================
// vx_dcr_req_fifo
//   Small synchronous FIFO holding packed DCR write requests.
//   DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-low reset (clears pointers/count)
//   push       in   write push_data at the tail (ignored while full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored while empty)
//   head_data  out  current head entry (valid while !empty)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// ============================================================================
module vx_dcr_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_reg;
    logic [PTR_BITS-1:0] rd_ptr_reg;
    logic [CNT_BITS-1:0] count_reg;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count_reg == CNT_BITS'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_BITS'(1);
                2'b01:   count_reg <= count_reg - CNT_BITS'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/vx_dcr_write_bridge.sv
// ============================================================================
// vx_dcr_write_bridge
//   Accepts host DCR writes on a valid/ready port, queues them in a FIFO and
//   replays them in order as single-cycle strobes on the DCR write master,
//   followed by GAP_CYCLES idle cycles so downstream retiming can settle.
//   'idle' tells host launch logic that every queued write has landed.
//
//   Optional feature, macro DCR_RANGE_CHECK_EN: entries whose address falls
//   outside the base-state DCR window are discarded at pop time (no strobe,
//   no gap) and counted in drop_count (saturating at 255). Without the macro
//   every entry is forwarded and drop_count is tied to zero.
//
// Ports
//   clk              in   clock
//   reset            in   synchronous, active-low reset
//   req_valid        in   host write request valid
//   req_ready        out  bridge can accept (from registered FIFO count)
//   req_addr         in   DCR address
//   req_data         in   DCR data
//   dcr_write_valid  out  write strobe, one cycle per write
//   dcr_write_addr   out  DCR address (holds last value while not valid)
//   dcr_write_data   out  DCR data    (holds last value while not valid)
//   idle             out  FIFO empty, FSM idle, no strobe in flight
//   drop_count       out  number of discarded requests
// ============================================================================
module vx_dcr_write_bridge
    import vx_dcr_write_bridge_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int ADDR_BITS  = DCR_ADDR_BITS,
    parameter int DATA_BITS  = DCR_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 dcr_write_valid,
    output logic [ADDR_BITS-1:0] dcr_write_addr,
    output logic [DATA_BITS-1:0] dcr_write_data,
    output logic                 idle,
    output logic [7:0]           drop_count
);

    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
    localparam logic [GAP_CNT_BITS-1:0] GAP_RELOAD =
        GAP_CNT_BITS'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [GAP_CNT_BITS-1:0] gap_cnt_reg, gap_cnt_next;

    logic                    valid_reg;
    logic [ADDR_BITS-1:0]    addr_reg;
    logic [DATA_BITS-1:0]    data_reg;

    logic                    push;
    logic                    pop;
    logic                    strobe;
    logic                    head_in_range;
    logic [ENTRY_BITS-1:0]   head_entry;
    logic [ADDR_BITS-1:0]    head_addr;
    logic [DATA_BITS-1:0]    head_data;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Ready comes straight from the registered count: a pop in the same
    // cycle does not reopen a full FIFO.
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    vx_dcr_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_addr = head_entry[ENTRY_BITS-1:DATA_BITS];
    assign head_data = head_entry[DATA_BITS-1:0];

`ifdef DCR_RANGE_CHECK_EN
    assign head_in_range = dcr_addr_in_range(32'(head_addr));
`else
    assign head_in_range = 1'b1;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                // A discarded entry never enters the gap.
                if (strobe && (GAP_CYCLES > 0)) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = GAP_RELOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_CNT_BITS'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pop    = 1'b0;
        strobe = 1'b0;
        if ((state_reg == ST_IDLE) && !fifo_empty) begin
            pop    = 1'b1;
            strobe = head_in_range;
        end
    end

    // Strobe register: valid lasts exactly one cycle, addr/data hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= strobe;
            if (strobe) begin
                addr_reg <= head_addr;
                data_reg <= head_data;
            end
        end
    end

    assign dcr_write_valid = valid_reg;
    assign dcr_write_addr  = addr_reg;
    assign dcr_write_data  = data_reg;

    assign idle = (fifo_count == '0) && (state_reg == ST_IDLE) && !valid_reg;

`ifdef DCR_RANGE_CHECK_EN
    logic       drop;
    logic [7:0] drop_count_reg;

    assign drop = pop && !strobe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count_reg <= '0;
        end else if (drop && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_vx_dcr_write_bridge.sv
// ============================================================================
// tb_vx_dcr_write_bridge
//   Randomised bench for vx_dcr_write_bridge (DEPTH=4, GAP_CYCLES=2).
//   The reference model works on edge numbers: every accepted write gets the
//   edge at which the bridge will take it from the FIFO, computed as
//   max(accept_edge + 1, earliest free issue edge). Forwarded writes occupy
//   1 + GAP issue slots, discarded writes occupy one. Strobes, req_ready,
//   idle and drop_count are all derived from that list of edges.
//   If DCR_RANGE_CHECK_EN is defined the model applies the address window.
// ============================================================================
module tb_vx_dcr_write_bridge;

    localparam int DEPTH    = 4;
    localparam int GAP      = 2;
    localparam int AB       = 12;
    localparam int DB       = 32;
    localparam int HOLD     = (GAP > 0) ? GAP : 1;
    localparam int RANGE_LO = 'h001;
    localparam int RANGE_HI = 'h00A;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AB-1:0] req_addr = '0;
    logic [DB-1:0] req_data = '0;
    logic          dcr_write_valid;
    logic [AB-1:0] dcr_write_addr;
    logic [DB-1:0] dcr_write_data;
    logic          idle;
    logic [7:0]    drop_count;

    vx_dcr_write_bridge #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .ADDR_BITS  (AB),
        .DATA_BITS  (DB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .dcr_write_valid (dcr_write_valid),
        .dcr_write_addr  (dcr_write_addr),
        .dcr_write_data  (dcr_write_data),
        .idle            (idle),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int acc;
        int pop;
        bit fwd;
    } rec_t;

    typedef struct {
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        int            edge_n;
    } exp_t;

    rec_t recs[$];
    exp_t exp_q[$];
    int   drop_pending[$];
    int   exp_drop  = 0;
    int   next_free = 0;
    int   checks    = 0;
    int   failures  = 0;
    bit   mon_en    = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit fwd_rule(input logic [AB-1:0] a);
`ifdef DCR_RANGE_CHECK_EN
        return (int'(a) >= RANGE_LO) && (int'(a) < RANGE_HI);
`else
        return (a === a);
`endif
    endfunction

    function automatic int busy_until(input rec_t r);
        return r.fwd ? (r.pop + HOLD) : r.pop;
    endfunction

    function automatic int occ_at(input int e);
        int n;
        n = 0;
        foreach (recs[i]) begin
            if (recs[i].acc <= e && recs[i].pop > e) n++;
        end
        return n;
    endfunction

    function automatic bit idle_at(input int e);
        foreach (recs[i]) begin
            if (recs[i].acc <= e && e < busy_until(recs[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_accept(input int acc_edge, input logic [AB-1:0] a,
                                         input logic [DB-1:0] d);
        int   p;
        bit   f;
        rec_t r;
        exp_t x;
        p = (acc_edge + 1 > next_free) ? acc_edge + 1 : next_free;
        f = fwd_rule(a);
        if (f) begin
            x.addr = a; x.data = d; x.edge_n = p;
            exp_q.push_back(x);
            next_free = p + 1 + GAP;
        end else begin
            drop_pending.push_back(p);
            next_free = p + 1;
        end
        r.acc = acc_edge; r.pop = p; r.fwd = f;
        recs.push_back(r);
        $display("ACCEPT edge=%0d addr=%03h data=%08h issue_edge=%0d forward=%0d",
                 acc_edge, a, d, p, f);
    endfunction

    function automatic void model_clear();
        recs.delete();
        exp_q.delete();
        drop_pending.delete();
        exp_drop  = 0;
        next_free = 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int   e;
        exp_t x;
        if (mon_en) begin
            e = cyc;
            while (drop_pending.size() > 0 && drop_pending[0] <= e) begin
                void'(drop_pending.pop_front());
                if (exp_drop < 255) exp_drop++;
            end

            checks++;
            if (drop_count !== 8'(exp_drop)) begin
                failures++;
                $display("FAIL drop_count edge=%0d got=%0d exp=%0d", e, drop_count, exp_drop);
            end

            checks++;
            if (req_ready !== (occ_at(e) != DEPTH)) begin
                failures++;
                $display("FAIL req_ready edge=%0d got=%b exp=%b", e, req_ready, occ_at(e) != DEPTH);
            end

            checks++;
            if (idle !== idle_at(e)) begin
                failures++;
                $display("FAIL idle edge=%0d got=%b exp=%b", e, idle, idle_at(e));
            end

            while (exp_q.size() > 0 && exp_q[0].edge_n < e) begin
                checks++;
                failures++;
                $display("FAIL missing_strobe edge=%0d got=none exp addr=%03h data=%08h at edge %0d",
                         e, exp_q[0].addr, exp_q[0].data, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end

            if (dcr_write_valid === 1'b1) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                    x = exp_q.pop_front();
                    if (dcr_write_addr !== x.addr || dcr_write_data !== x.data) begin
                        failures++;
                        $display("FAIL strobe_payload edge=%0d got=%03h/%08h exp=%03h/%08h",
                                 e, dcr_write_addr, dcr_write_data, x.addr, x.data);
                    end else begin
                        $display("STROBE edge=%0d addr=%03h data=%08h", e, dcr_write_addr, dcr_write_data);
                    end
                end else begin
                    failures++;
                    $display("FAIL unexpected_strobe edge=%0d got addr=%03h data=%08h exp=no strobe",
                             e, dcr_write_addr, dcr_write_data);
                end
            end else if (dcr_write_valid !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL strobe_valid edge=%0d got=%b exp=0/1", e, dcr_write_valid);
            end

            while (recs.size() > 0 && busy_until(recs[0]) <= e) void'(recs.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [AB-1:0] a, input logic [DB-1:0] d,
                         output bit acc);
        @(negedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        acc = v && (occ_at(cyc) != DEPTH);
        if (acc) model_accept(cyc + 1, a, d);
    endtask

    task automatic push_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) drive(1'b1, a, d, acc);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=not accepted exp=accepted within 50 cycles addr=%03h", a);
        end
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        reset = 1'b1;
        $display("RESET applied at edge %0d", cyc);
    endtask

    function automatic logic [AB-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1: return AB'($urandom_range(RANGE_LO, RANGE_HI - 1));
            2: begin
                case ($urandom_range(0, 3))
                    0: return AB'(RANGE_LO - 1);
                    1: return AB'(RANGE_LO);
                    2: return AB'(RANGE_HI - 1);
                    default: return AB'(RANGE_HI);
                endcase
            end
            default: return AB'($urandom_range(0, (1 << AB) - 1));
        endcase
    endfunction

    initial begin
        bit acc;
        int t;

        repeat (3) @(negedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        checks++;
        if (dcr_write_valid !== 1'b0 || dcr_write_addr !== '0 || dcr_write_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b a=%03h d=%08h exp=0/000/00000000",
                     dcr_write_valid, dcr_write_addr, dcr_write_data);
        end

        // Single write: strobe two edges after acceptance.
        push_write(12'h001, 32'hDEAD_BEEF);
        idle_cycles(6);

        // Window boundaries.
        push_write(AB'(RANGE_LO - 1), 32'h1111_0000);
        push_write(AB'(RANGE_LO),     32'h2222_0001);
        push_write(AB'(RANGE_HI - 1), 32'h3333_0009);
        push_write(AB'(RANGE_HI),     32'h4444_000A);
        push_write(12'hFFF,           32'h5555_0FFF);
        idle_cycles(8);

        // Six continuous writes: FIFO fills, ready drops, strobes GAP+1 apart.
        for (int i = 0; i < 6; i++) push_write(AB'(RANGE_LO + i), $urandom());
        idle_cycles(20);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 3) != 0, rand_addr(), $urandom(), acc);
        end
        idle_cycles(20);

        // Reset with writes still queued: they must never appear.
        for (int i = 0; i < 4; i++) push_write(AB'(RANGE_LO + 1), 32'hABCD_0000 + 32'(i));
        do_reset();
        idle_cycles(8);

        for (int i = 0; i < 100; i++) begin
            drive($urandom_range(0, 1) != 0, rand_addr(), $urandom(), acc);
        end

        // Long run of out-of-window writes (saturates drop_count when filtering).
        for (int i = 0; i < 300; i++) begin
            push_write(AB'($urandom_range(RANGE_HI, (1 << AB) - 1)), $urandom());
        end

        t = 0;
        while ((exp_q.size() > 0 || drop_pending.size() > 0 || !idle_at(cyc)) && t < 3000) begin
            idle_cycles(1);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d pending strobes exp=0", exp_q.size());
        end
        idle_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
